// File: rtl/rv32imf_data_mem_responder.sv
// Responder side of the core's OBI-style data bus: word-organised RAM with byte-enabled
// writes, bounded outstanding transactions and in-order responses after a fixed latency.
module rv32imf_data_mem_responder #(
    parameter int DEPTH_WORDS     = 4096,
    parameter int RVALID_LATENCY  = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        stall_i
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    logic [31:0]               mem_q [DEPTH_WORDS];
    logic [AW-1:0]             idx;
    logic                      accept;
    logic                      mem_we;
    logic [2:0]                outst_q, outst_d;
    logic [RVALID_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]               data_q [RVALID_LATENCY];
    logic [31:0]               data_d [RVALID_LATENCY];
    logic                      unused_addr_bits;

    // Upper address bits wrap modulo depth; byte offset is irrelevant for word access.
    assign idx              = addr_i[AW+1:2];
    assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

    assign gnt_o    = req_i & ~stall_i & ((outst_q < MAX_OUT) | rvalid_o);
    assign accept   = req_i & gnt_o;
    assign mem_we   = accept & we_i & rst_ni;
    assign rvalid_o = vld_q[RVALID_LATENCY-1];
    assign rdata_o  = data_q[RVALID_LATENCY-1];

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Write responses carry zero data, so the output register needs no masking.
    always_comb begin
        vld_d[0]  = accept;
        data_d[0] = (accept && !we_i) ? mem_q[idx] : 32'h0;
        for (int i = 1; i < RVALID_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    always_comb begin
        outst_d = outst_q + {2'b00, accept} - {2'b00, rvalid_o};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q   <= '0;
            outst_q <= 3'd0;
            for (int i = 0; i < RVALID_LATENCY; i++) begin
                data_q[i] <= 32'h0;
            end
        end else begin
            vld_q   <= vld_d;
            outst_q <= outst_d;
            for (int i = 0; i < RVALID_LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rv32imf_data_mem_responder.sv
// Scoreboard bench: three responders (latency 1, 2, 3; depth 16; two outstanding) share
// one stimulus bus, with req routed to the selected instance.
module tb_rv32imf_data_mem_responder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  be    = 4'h0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    int          sel   = 0;

    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [31:0] rdata [3];

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int          g;
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rv32imf_data_mem_responder #(
            .DEPTH_WORDS    (16),
            .RVALID_LATENCY (g + 1),
            .MAX_OUTSTANDING(2)
        ) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .req_i   (req & (sel == g)),
            .gnt_o   (gnt[g]),
            .we_i    (we),
            .be_i    (be),
            .addr_i  (addr),
            .wdata_i (wdata),
            .rvalid_o(rvalid[g]),
            .rdata_o (rdata[g]),
            .stall_i (stall)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every response pops the oldest expectation and checks instance, data, cycle.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rvalid[g]) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: inst %0d data %h, none expected", g, rdata[g]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_inst", 32'(g), 32'(e.g));
                    chk("rsp_data", rdata[g], e.d);
                    chk("rsp_cycle", 32'(cyc), 32'(e.c));
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic xfer(input int g, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] ex, input bit push,
                        output int acc, output int waited);
        exp_t e;
        sel = g; req = 1'b1; we = w; be = b; addr = a; wdata = d;
        waited = 0;
        acc = -1;
        @(negedge clk);
        while (!gnt[g] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!gnt[g]) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: inst %0d addr %h got no grant, required grant", g, a);
            req = 1'b0;
            return;
        end
        acc = cyc;
        if (push) begin
            e.g = g; e.d = ex; e.c = acc + g + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, a1, a2, a3, w0, w1;
        int acc4 [4];

        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata0", rdata[0], 32'h0);
        chk("rst_gnt_idle", 32'(gnt), 32'd0);
        sel = 0; req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0;
        #1;
        chk("rst_gnt_req", 32'(gnt[0]), 32'd1);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read, L=1
        xfer(0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 32'h0, 1'b1, a0, w0);
        xfer(0, 1'b0, 4'hF, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1, a1, w1);
        chk("wr_gnt_wait", 32'(w0), 32'd0);
        chk("rd_gnt_wait", 32'(w1), 32'd0);
        chk("wr_rd_b2b", 32'(a1 - a0), 32'd1);
        drain();

        // Byte enables, including an all-zero enable write
        xfer(0, 1'b1, 4'hF, 32'h80, 32'h11223344, 32'h0, 1'b1, a0, w0);
        xfer(0, 1'b1, 4'b0101, 32'h80, 32'hAABBCCDD, 32'h0, 1'b1, a0, w0);
        xfer(0, 1'b0, 4'h0, 32'h80, 32'h0, 32'h11BB33DD, 1'b1, a0, w0);
        xfer(0, 1'b1, 4'h0, 32'h80, 32'hFFFFFFFF, 32'h0, 1'b1, a0, w0);
        xfer(0, 1'b0, 4'hF, 32'h80, 32'h0, 32'h11BB33DD, 1'b1, a0, w0);
        drain();

        // Backpressure then address wrap on a 16-word RAM
        stall = 1'b1; sel = 0; req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h44; wdata = 32'h5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_gnt", 32'(gnt[0]), 32'd0);
            chk("stall_rvalid", 32'(rvalid[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        xfer(0, 1'b1, 4'hF, 32'h44, 32'h5, 32'h0, 1'b1, a0, w0);
        chk("unstall_gnt_wait", 32'(w0), 32'd0);
        xfer(0, 1'b0, 4'hF, 32'h04, 32'h0, 32'h5, 1'b1, a0, w0);
        drain();

        // Outstanding limit, L=3, two outstanding
        for (int i = 0; i < 4; i++) begin
            xfer(2, 1'b1, 4'hF, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 32'h0, 1'b1, a0, w0);
        end
        drain();
        for (int i = 0; i < 4; i++) begin
            xfer(2, 1'b0, 4'hF, 32'h100 + 32'(4 * i), 32'h0, 32'hC0DE0000 + 32'(i), 1'b1, acc4[i], w0);
        end
        chk("outst_gnt1", 32'(acc4[1] - acc4[0]), 32'd1);
        chk("outst_gnt2", 32'(acc4[2] - acc4[0]), 32'd3);
        chk("outst_gnt3", 32'(acc4[3] - acc4[0]), 32'd4);
        drain();

        // Reset mid-operation, L=2; the write attempted during reset must not land
        xfer(1, 1'b1, 4'hF, 32'h08, 32'h12345678, 32'h0, 1'b1, a0, w0);
        drain();
        xfer(1, 1'b0, 4'hF, 32'h08, 32'h0, 32'h0, 1'b0, a0, w0);
        rst_n = 1'b0;
        sel = 1; req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h08; wdata = 32'hBADBAD00;
        @(negedge clk);
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_rdata", rdata[1], 32'h0);
        chk("mid_rst_gnt", 32'(gnt[1]), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_rvalid2", 32'(rvalid), 32'd0);
        chk("mid_rst_rdata2", rdata[1], 32'h0);
        req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(1, 1'b0, 4'hF, 32'h08, 32'h0, 32'h12345678, 1'b1, a2, a3);
        drain();

        chk("sb_final_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32imf_data_mem_responder.md
# rv32imf_data_mem_responder

Responder end of the core's OBI-style data bus (`data_req`/`data_gnt`/`data_rvalid`). It is a word-organised on-chip data RAM that grants requests, applies byte-enabled writes and returns in-order responses after a fixed, parameterised latency. It sits beside `rv32imf` in integration and test harnesses. Its `stall_i` input lets a bench inject grant backpressure.

## Interface
- `DEPTH_WORDS`, 4096: RAM depth in 32-bit words; power of two, ≥ 2.
- `RVALID_LATENCY`, 1: cycles from grant edge to `rvalid_o`; legal range 1..4.
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unanswered transactions; legal range 1..4.
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  request granted (combinational).
- `we_i`  in  1  1 = write, 0 = read.
- `be_i`  in  4  byte enables; `be_i[k]` covers bits `8k+7:8k`.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  write data.
- `rvalid_o`  out  1  response valid, one cycle per transaction.
- `rdata_o`  out  32  read data; 0 when `rvalid_o`=0 or on a write response.
- `stall_i`  in  1  backpressure injection; forces `gnt_o`=0.

## Operation
- **Grant:** `gnt_o = req_i & ~stall_i & (outstanding < MAX_OUTSTANDING | rvalid_o)`.
  - Freeing a slot in the same cycle via `rvalid_o` permits a grant.
- **Acceptance:** a transaction is accepted on a rising edge with `req_i & gnt_o`.
  - `addr_i`, `we_i`, `be_i` and `wdata_i` are sampled only at acceptance.
- **Index:** `addr_i[log2(DEPTH_WORDS)+1:2]`.
  - `addr_i[1:0]` and upper bits are ignored, so out-of-range addresses wrap modulo depth.
- **Write:** at the acceptance edge, only bytes with `be_i[k]`=1 are updated. `be_i`=0000 leaves the RAM unchanged but still produces a response.
- **Read:** the full 32-bit word is captured at the acceptance edge, before any later write. `be_i` is ignored for reads and no byte masking is applied to `rdata_o`.
- **Back-to-back access:** read-after-write to the same word on consecutive accepted cycles returns the new data.
- **Response pipeline:** shift register of depth `RVALID_LATENCY`. Each entry holds {valid, we, data}.
  - The response appears exactly `RVALID_LATENCY` cycles after acceptance, in order, never merged or dropped.
- **Outstanding counter:** width 3 bits.
  - +1 on acceptance, −1 on `rvalid_o`.
  - Both in the same cycle leaves it unchanged.
  - It never exceeds `MAX_OUTSTANDING`.
- **No stall on response side:** the requester must always accept `rvalid_o`.
- **Reset (asynchronous assert, any time, including mid-transaction):**
  - Pipeline valids cleared, so in-flight responses are discarded.
  - Outstanding counter = 0, `rvalid_o`=0, `rdata_o`=0.
  - `gnt_o` follows its equation (0 while `req_i`=0).
  - RAM contents are not reset and retain their values.
- **Deassertion:** reset deasserts synchronously to the first clock edge as seen by the flops. No transaction is accepted on that edge if `rst_ni` is low.

## Timing
- **Latency:** `RVALID_LATENCY` cycles from acceptance edge to `rvalid_o` high.
  - With L=1, a grant at edge n gives `rvalid_o` during cycle n→n+1.
- **Throughput:** one transaction per cycle when `MAX_OUTSTANDING ≥ RVALID_LATENCY`. Otherwise the rate is limited to `MAX_OUTSTANDING` per `RVALID_LATENCY` cycles.
- **Grant timing:** `gnt_o` depends combinationally on `req_i`, `stall_i` and registered state only.
- **Outputs:** `rvalid_o` and `rdata_o` are registered, with no combinational input-to-output path.

## Test plan
- **Write then read, L=1:**
  - Write 0xDEADBEEF to 0x40 with be=1111, then read 0x40.
  - Expect `gnt_o`=1 both cycles and `rvalid_o` one cycle after each grant.
  - Second `rdata_o`=0xDEADBEEF; first (write) `rdata_o`=0.
- **Byte enables:**
  - Preload 0x11223344 at 0x80, write 0xAABBCCDD with be=0101, read 0x80.
  - Expect 0x11BB33DD.
- **Backpressure and wrap, DEPTH_WORDS=16:**
  - Hold `stall_i`=1 for 3 cycles with `req_i`=1: `gnt_o`=0 and no response.
  - Release `stall_i`: grant on the next edge.
  - Write 0x5 to 0x44, read 0x04: expect 0x5 (wrap).
- **Outstanding limit, L=3, MAX_OUTSTANDING=2:**
  - Issue 4 back-to-back reads with `req_i` held.
  - Grants at cycles 0, 1, 3, 4.
  - `rvalid_o` at 3, 4, 6, 7, with data in issue order.
- **Reset mid-operation, L=2:**
  - Grant a read, then assert `rst_ni`=0 the next cycle.
  - Expect no `rvalid_o` for that read and outputs 0.
  - After release, reading the previously written word returns the pre-reset value.
